// File: rtl/mac_seq_pkg.sv
// Shared types and timing constants for the sequenced MAC controller.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StDone
  } state_e;

  // Read latency of the shared coefficient/sample memory.
  localparam int unsigned MEM_LAT   = 1;
  // Cycles between the last issued address and a settled MAC output.
  localparam int unsigned DRAIN_CYC = 2;

endpackage

// File: rtl/mac_seq_sat.sv
// Signed saturation of a WIDTH-bit accumulator value to OUT_WIDTH bits.
module mac_seq_sat #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [WIDTH-1:0]     value_i,
  output logic [OUT_WIDTH-1:0] result_o
);

  // Value fits when every bit from the output sign bit upward agrees.
  logic [WIDTH-OUT_WIDTH:0] upper;
  assign upper = value_i[WIDTH-1:OUT_WIDTH-1];

  always_comb begin
    result_o = value_i[OUT_WIDTH-1:0];
    if (!((&upper) || (~|upper))) begin
      result_o = value_i[WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_seq.sv
// Sequencer for an external MAC: clears it, streams N tap addresses, drains and
// captures the result. Define MAC_SEQ_SATURATE_EN for signed saturation of the result.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic [ADDR_WIDTH:0]   NumTaps_DI,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic                  MacClr_SO,
  output logic                  MacEn_SO,
  input  logic [WIDTH-1:0]      MacOut_DI,
  output logic [OUT_WIDTH-1:0]  Result_DO,
  output logic                  Valid_SO,
  input  logic                  Ready_SI,
  output logic                  Busy_SO
);

  localparam logic [1:0] DrainLast = 2'(DRAIN_CYC - 1);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            drain_q;
  logic                  clr_q;
  logic                  en_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [OUT_WIDTH-1:0]  result_q;

  logic [OUT_WIDTH-1:0]  res_conv;
  logic [ADDR_WIDTH:0]   n_clamped;
  logic                  last_addr;

`ifdef MAC_SEQ_SATURATE_EN
  mac_seq_sat #(
    .WIDTH    (WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat (
    .value_i (MacOut_DI),
    .result_o(res_conv)
  );
`else
  assign res_conv = MacOut_DI[OUT_WIDTH-1:0];
  if (OUT_WIDTH < WIDTH) begin : g_wrap_unused
    logic unused_mac_hi;
    assign unused_mac_hi = ^MacOut_DI[WIDTH-1:OUT_WIDTH];
  end
`endif

  // Any count with the top bit set is at least 2^ADDR_WIDTH.
  assign n_clamped = NumTaps_DI[ADDR_WIDTH] ? {1'b1, {ADDR_WIDTH{1'b0}}} : NumTaps_DI;
  assign last_addr = (({1'b0, addr_q} + (ADDR_WIDTH+1)'(1)) == n_q);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= StIdle;
      n_q      <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start_SI) begin
            n_q     <= n_clamped;
            clr_q   <= 1'b1;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          clr_q <= 1'b0;
          en_q  <= 1'b0;
          if (n_q != '0) begin
            addr_q  <= '0;
            state_q <= StAccum;
          end else begin
            result_q <= '0;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StAccum: begin
          // Data for the address issued now reaches the MAC next cycle.
          en_q <= 1'b1;
          if (last_addr) begin
            addr_q  <= '0;
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        StDrain: begin
          en_q <= 1'b0;
          if (drain_q == DrainLast) begin
            result_q <= res_conv;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          if (Ready_SI) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Addr_DO   = addr_q;
  assign MacClr_SO = clr_q;
  assign MacEn_SO  = en_q;
  assign Result_DO = result_q;
  assign Valid_SO  = valid_q;
  assign Busy_SO   = busy_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural memory and MAC (a = b = addr + 1).
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  num_taps;
  logic [5:0]  addr;
  logic        mac_clr;
  logic        mac_en;
  logic [23:0] mac_out;
  logic [15:0] result;
  logic        valid;
  logic        ready;
  logic        busy;

  logic [7:0]  rd_q;
  logic [23:0] acc_q;
  logic        ovr_en;
  logic [23:0] ovr_val;

  int checks   = 0;
  int failures = 0;

  int lat, pulses, clrs;
  bit addr_err, busy_err;

  always #5 clk = ~clk;

  mac_seq dut (
    .Clk_CI    (clk),
    .Rst_RBI   (rst_n),
    .Start_SI  (start),
    .NumTaps_DI(num_taps),
    .Addr_DO   (addr),
    .MacClr_SO (mac_clr),
    .MacEn_SO  (mac_en),
    .MacOut_DI (mac_out),
    .Result_DO (result),
    .Valid_SO  (valid),
    .Ready_SI  (ready),
    .Busy_SO   (busy)
  );

  // Memory with one cycle read latency, then a registered multiply-accumulate.
  always @(posedge clk) begin
    rd_q <= {2'b00, addr} + 8'd1;
    if (mac_clr) acc_q <= '0;
    else if (mac_en) acc_q <= acc_q + 24'(rd_q) * 24'(rd_q);
  end

  assign mac_out = ovr_en ? ovr_val : acc_q;

  // Called at a negedge; returns at the negedge where valid is first seen.
  task automatic run_op(input logic [6:0] n, input int ne);
    int ea;
    lat = -1; pulses = 0; clrs = 0; addr_err = 0; busy_err = 0;
    start = 1'b1;
    num_taps = n;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      ea = (c >= 2 && c <= ne + 1) ? c - 2 : 0;
      if (addr !== 6'(ea)) addr_err = 1;
      if (mac_en === 1'b1 && mac_clr === 1'b0) pulses++;
      if (mac_clr === 1'b1) clrs++;
      if (busy !== 1'b1) busy_err = 1;
      if (valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; num_taps = '0; ready = 1'b1; ovr_en = 1'b0; ovr_val = '0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr, mac_clr, mac_en, result, valid, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {addr, mac_clr, mac_en, result, valid, busy});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_n4();
    run_op(7'd4, 4);
    checks++;
    if (lat != 8) begin failures++; $display("FAIL n4_latency: got %0d expected 8", lat); end
    checks++;
    if (pulses != 4) begin failures++; $display("FAIL n4_macen: got %0d expected 4", pulses); end
    checks++;
    if (clrs != 1) begin failures++; $display("FAIL n4_clear: got %0d expected 1", clrs); end
    checks++;
    if (addr_err) begin failures++; $display("FAIL n4_addr: got bad sequence expected 0..3"); end
    checks++;
    if (busy_err) begin failures++; $display("FAIL n4_busy: got low expected high"); end
    checks++;
    if (result !== 16'd30) begin failures++; $display("FAIL n4_result: got %0d expected 30", result); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL n4_to_idle: got valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_n0();
    run_op(7'd0, 0);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL n0_latency: got %0d expected 2", lat); end
    checks++;
    if (pulses != 0 || clrs != 1) begin
      failures++;
      $display("FAIL n0_strobes: got en=%0d clr=%0d expected 0 1", pulses, clrs);
    end
    checks++;
    if (result !== 16'd0) begin failures++; $display("FAIL n0_result: got %0d expected 0", result); end
    @(negedge clk);
  endtask

  task automatic test_ready_hold();
    ready = 1'b0;
    run_op(7'd3, 3);
    checks++;
    if (lat != 7 || result !== 16'd14) begin
      failures++;
      $display("FAIL hold_first: got lat=%0d res=%0d expected 7 14", lat, result);
    end
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || result !== 16'd14 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable: got v=%b res=%0d busy=%b expected 1 14 1", valid, result, busy);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: got v=%b busy=%b expected 0 0", valid, busy);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL hold_no_start: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    start = 1'b1;
    num_taps = 7'd8;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (addr === 6'd3) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_addr3: got timeout expected addr 3"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || addr !== 6'd0 || mac_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_ctrl: got busy=%b addr=%0d en=%b expected 0 0 0", busy, addr, mac_en);
    end
    checks++;
    if (result !== 16'd0 || valid !== 1'b0 || mac_clr !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_data: got res=%0d v=%b clr=%b expected 0 0 0", result, valid, mac_clr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_op(7'd2, 2);
    checks++;
    if (lat != 6 || result !== 16'd5 || pulses != 2) begin
      failures++;
      $display("FAIL mid_rerun: got lat=%0d res=%0d en=%0d expected 6 5 2", lat, result, pulses);
    end
    @(negedge clk);
  endtask

  task automatic test_clamp();
    logic [15:0] exp_res;
`ifdef MAC_SEQ_SATURATE_EN
    exp_res = 16'h7FFF;
`else
    exp_res = 16'h5D60;
`endif
    run_op(7'd100, 64);
    checks++;
    if (lat != 68 || pulses != 64) begin
      failures++;
      $display("FAIL clamp_len: got lat=%0d en=%0d expected 68 64", lat, pulses);
    end
    checks++;
    if (addr_err) begin failures++; $display("FAIL clamp_addr: got bad sequence expected 0..63"); end
    checks++;
    if (result !== exp_res) begin failures++; $display("FAIL clamp_result: got %h expected %h", result, exp_res); end
    @(negedge clk);
  endtask

  task automatic test_sat();
    logic [15:0] exp_pos, exp_neg;
`ifdef MAC_SEQ_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'hFFFF; exp_neg = 16'h0000;
`endif
    ovr_en = 1'b1;
    ovr_val = 24'h7FFFFF;
    run_op(7'd1, 1);
    checks++;
    if (result !== exp_pos) begin failures++; $display("FAIL sat_pos: got %h expected %h", result, exp_pos); end
    @(negedge clk);
    ovr_val = 24'h800000;
    run_op(7'd1, 1);
    checks++;
    if (result !== exp_neg) begin failures++; $display("FAIL sat_neg: got %h expected %h", result, exp_neg); end
    @(negedge clk);
    ovr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(7'd2, 2);
    checks++;
    if (result !== 16'd5) begin failures++; $display("FAIL b2b_first: got %0d expected 5", result); end
    @(negedge clk);
    run_op(7'd1, 1);
    checks++;
    if (lat != 5 || result !== 16'd1) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d res=%0d expected 5 1", lat, result);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_n4();
    test_n0();
    test_ready_hold();
    test_reset_mid();
    test_clamp();
    test_sat();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 24, the accumulator width of the sequenced MAC.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, the result width, with OUT_WIDTH <= WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, the tap address width; max taps = 2^ADDR_WIDTH.
REQ-004 SHALL have port Clk_CI, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port Rst_RBI, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port Start_SI, input, 1 bit: begin one dot product; sampled only in IDLE.
REQ-007 SHALL have port NumTaps_DI, input, ADDR_WIDTH+1 bits: tap count N, latched on accepted Start.
REQ-008 SHALL have port Addr_DO, output, ADDR_WIDTH bits: shared coefficient/sample memory read address.
REQ-009 SHALL have port MacClr_SO, output, 1 bit: MAC clear strobe.
REQ-010 SHALL have port MacEn_SO, output, 1 bit: MAC write enable.
REQ-011 SHALL have port MacOut_DI, input, WIDTH bits: MAC accumulator value.
REQ-012 SHALL have port Result_DO, output, OUT_WIDTH bits: registered result.
REQ-013 SHALL have port Valid_SO, output, 1 bit: Result_DO valid.
REQ-014 SHALL have port Ready_SI, input, 1 bit: consumer accepts result.
REQ-015 SHALL have port Busy_SO, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN, DONE.
REQ-017 IDLE: Start_SI=1 SHALL latch N and move to CLEAR; otherwise stay.
REQ-018 CLEAR: SHALL assert MacClr_SO and MacEn_SO for exactly one cycle, then go to ACCUM if N>0, else DONE with Result_DO=0.
REQ-019 ACCUM: SHALL drive Addr_DO = 0,1,...,N-1 on consecutive cycles, one per cycle, then go to DRAIN.
REQ-020 Memory read latency is 1 cycle; MacEn_SO SHALL be the 1-cycle-registered "address issued" flag, so exactly N MacEn pulses follow CLEAR.
REQ-021 DRAIN: SHALL last exactly 2 cycles (last MAC write, then MAC output settle); at its end SHALL capture MacOut_DI into Result_DO and enter DONE.
REQ-022 DONE: Valid_SO=1, Result_DO stable; Valid_SO & Ready_SI SHALL return to IDLE next cycle.
REQ-023 Start_SI outside IDLE SHALL be ignored; Start in the cycle DONE completes is not accepted.
REQ-024 Start-to-Valid latency SHALL be N+4 cycles for N>0 and 2 cycles for N=0.
REQ-025 N > 2^ADDR_WIDTH SHALL be clamped to 2^ADDR_WIDTH.
REQ-026 Addr_DO SHALL be 0 outside ACCUM.

Reset
REQ-027 Rst_RBI low SHALL immediately force IDLE, Addr_DO=0, MacClr_SO=0, MacEn_SO=0, Result_DO=0, Valid_SO=0, Busy_SO=0, including mid-operation.
REQ-028 After reset release the first Start SHALL behave identically to a fresh run.

Configuration
REQ-029 With MAC_SEQ_SATURATE_EN defined, Result_DO SHALL be MacOut_DI (signed) saturated to OUT_WIDTH signed range.
REQ-030 Without MAC_SEQ_SATURATE_EN, Result_DO SHALL be the low OUT_WIDTH bits of MacOut_DI (wrap).

Structure
REQ-031 Package mac_seq_pkg SHALL hold the state enum, MEM_LAT=1 and DRAIN_CYC=2 constants.
REQ-032 Saturation SHALL be a sub-module mac_seq_sat (combinational, WIDTH->OUT_WIDTH), instantiated only under MAC_SEQ_SATURATE_EN.

Verification
REQ-033 N=4, Ready=1, memory a=b=1..4 with real MAC -> addresses 0..3, 4 MacEn pulses, Valid at cycle 8 after Start, Result=30.
REQ-034 N=0 -> one clear cycle, Valid 2 cycles after Start, Result=0, no MacEn.
REQ-035 Ready held 0 for 5 cycles in DONE, Start pulsed -> Result/Valid stable, Start ignored, IDLE one cycle after Ready=1.
REQ-036 Rst_RBI low during ACCUM (N=8, addr 3) -> all outputs 0 asynchronously; next Start with N=2 gives correct result.
REQ-037 MacOut=0x7FFFFF with OUT_WIDTH=16 -> Result 0x7FFF with MAC_SEQ_SATURATE_EN, 0xFFFF without.
